if_fetch_unit: RTL and testbench

- Consumer end of the pipeline-control interface: applies `stall_i`, `flush_jump_i` and `new_pc_i` to the front of the pipe.
- Owns the PC register, the instruction-memory request/acknowledge handshake, a one-entry hold buffer and the IF/ID pipeline register.
- Sits between the instruction memory and the ID stage.
- Drives the fetched {pc, instruction, valid} into ID every cycle.

---
 rtl/if_fetch_unit_pkg.sv | 26 ++
 rtl/if_fetch_unit_if.sv | 30 +++
 rtl/if_fetch_unit_if_id_reg.sv | 60 ++++++
 rtl/if_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package if_fetch_unit_pkg;

  // Default address and instruction widths
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  // Instruction placed in the IF/ID register for a bubble (addi x0, x0, 0)
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Positions in the controller's stall vector
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  // Value of a stall bit that requests a stop
  localparam logic STOP = 1'b1;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_HOLD  = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  inst_req_o;
  logic [ADDR_WIDTH-1:0] inst_addr_o;
  logic                  inst_ack_i;
  logic [DATA_WIDTH-1:0] inst_rdata_i;

  // Fetch-unit side: issues requests, receives ack and data
  modport master (
    output inst_req_o,
    output inst_addr_o,
    input  inst_ack_i,
    input  inst_rdata_i
  );

  // Memory side: observes requests, answers with ack and data
  modport slave (
    input  inst_req_o,
    input  inst_addr_o,
    output inst_ack_i,
    output inst_rdata_i
  );

endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: applies flush / bubble / hold / load priority to
// the {pc, instruction, valid} triple handed to the decode stage.
module if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  // bit 0: IF hold, bit 1: ID hold
  input  logic [1:0]            stall_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] entry_pc_i,
  input  logic [DATA_WIDTH-1:0] entry_inst_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic                  valid_o
);

  localparam logic [DATA_WIDTH-1:0] BUBBLE_INST = DATA_WIDTH'(NOP_INST);

  logic                  stall_if;
  logic                  stall_id;
  logic [ADDR_WIDTH-1:0] pc_p1;
  logic [DATA_WIDTH-1:0] inst_p1;
  logic                  vld_p1;

  assign stall_if = (stall_i[0] == STOP);
  assign stall_id = (stall_i[1] == STOP);

  // ---- IF -> ID stage boundary ----
  // Flush beats everything; an IF-only stall inserts a bubble so ID can drain,
  // a stall of both IF and ID freezes the register, otherwise take the entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      inst_p1 <= BUBBLE_INST;
      pc_p1   <= '0;
    end else if (flush_i || (stall_if && !stall_id)) begin
      vld_p1  <= 1'b0;
      inst_p1 <= BUBBLE_INST;
    end else if (!stall_if) begin
      if (load_i) begin
        vld_p1  <= 1'b1;
        pc_p1   <= entry_pc_i;
        inst_p1 <= entry_inst_i;
      end else begin
        vld_p1  <= 1'b0;
        inst_p1 <= BUBBLE_INST;
      end
    end
  end

  assign pc_o    = pc_p1;
  assign inst_o  = inst_p1;
  assign valid_o = vld_p1;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the PC, the single-outstanding memory request,
// a one-entry hold buffer for fetches that land while IF is stalled, and the
// IF/ID register feeding decode.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           PC_STEP    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [5:0]            stall_i,
  input  logic                  flush_jump_i,
  input  logic [ADDR_WIDTH-1:0] new_pc_i,
  if_fetch_unit_if.master       mem,
  output logic [ADDR_WIDTH-1:0] id_pc_o,
  output logic [DATA_WIDTH-1:0] id_inst_o,
  output logic                  id_valid_o
);

  // PC increment; wraps modulo 2^ADDR_WIDTH by construction
  function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] pc);
    return pc + ADDR_WIDTH'(PC_STEP);
  endfunction

  if_state_e             state_q;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  hold_vld_q;
  logic [ADDR_WIDTH-1:0] hold_pc_q;
  logic [DATA_WIDTH-1:0] hold_inst_q;

  logic                  ack;
  logic                  stall_if;
  logic                  req_ack;
  logic                  hold_release;
  logic                  hold_capture;
  logic                  unacked;
  logic                  load;
  logic [ADDR_WIDTH-1:0] entry_pc;
  logic [DATA_WIDTH-1:0] entry_inst;
  logic                  unused_stall_bits;

  assign ack      = mem.inst_ack_i;
  assign stall_if = (stall_i[STALL_IF] == STOP);

  // Only the IF and ID hold bits matter to the front of the pipe
  assign unused_stall_bits = ^{stall_i[5:3], stall_i[0]};

  // A fetch completes only in REQ with the request line up and memory accepting
  assign req_ack      = (state_q == IF_REQ) && req_q && ack;
  assign hold_release = (state_q == IF_HOLD) && hold_vld_q && !stall_if;
  assign hold_capture = req_ack && stall_if && !flush_jump_i;
  // A request still waiting for memory cannot be withdrawn; a redirect must drain it
  assign unacked      = req_q && !ack && ((state_q == IF_REQ) || (state_q == IF_DRAIN));

  assign load       = req_ack || hold_release;
  assign entry_pc   = (state_q == IF_HOLD) ? hold_pc_q   : addr_q;
  assign entry_inst = (state_q == IF_HOLD) ? hold_inst_q : mem.inst_rdata_i;

  // Fetch sequencer: state, registered request/address, PC and hold-buffer occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IF_IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      pc_q       <= RESET_PC;
      hold_vld_q <= 1'b0;
    end else if (flush_jump_i) begin
      pc_q       <= new_pc_i;
      hold_vld_q <= 1'b0;
      if (unacked) begin
        // keep the old address on the bus until memory answers, then discard it
        state_q <= IF_DRAIN;
      end else begin
        state_q <= IF_REQ;
        req_q   <= 1'b1;
        addr_q  <= new_pc_i;
      end
    end else begin
      case (state_q)
        IF_IDLE: begin
          state_q <= IF_REQ;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end
        IF_REQ: begin
          if (!req_q) begin
            // address is registered, so a new request starts one cycle after an ack
            req_q  <= 1'b1;
            addr_q <= pc_q;
          end else if (ack) begin
            req_q <= 1'b0;
            pc_q  <= pc_inc(addr_q);
            if (stall_if) begin
              state_q    <= IF_HOLD;
              hold_vld_q <= 1'b1;
            end
          end
        end
        IF_HOLD: begin
          if (!stall_if) begin
            state_q    <= IF_REQ;
            req_q      <= 1'b1;
            addr_q     <= pc_q;
            hold_vld_q <= 1'b0;
          end
        end
        IF_DRAIN: begin
          if (ack) begin
            state_q <= IF_REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        default: begin
          state_q <= IF_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Hold-buffer payload; occupancy is tracked by hold_vld_q
  always_ff @(posedge clk_i) begin
    if (hold_capture) begin
      hold_pc_q   <= addr_q;
      hold_inst_q <= mem.inst_rdata_i;
    end
  end

  assign mem.inst_req_o  = req_q;
  assign mem.inst_addr_o = addr_q;

  if_id_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if_id_reg (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_jump_i),
    .stall_i      (stall_i[STALL_ID:STALL_IF]),
    .load_i       (load),
    .entry_pc_i   (entry_pc),
    .entry_inst_i (entry_inst),
    .pc_o         (id_pc_o),
    .inst_o       (id_inst_o),
    .valid_o      (id_valid_o)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a combinational instruction memory answers requests,
// each scenario task drives stall/flush/reset and pushes the PCs it expects ID
// to receive; a scoreboard pops one entry per valid IF/ID word.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic [AW-1:0] new_pc;
  logic [AW-1:0] id_pc;
  logic [DW-1:0] id_inst;
  logic          id_valid;
  logic          ack_block;
  logic          sb_en;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] sb_pc;

  if_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  if_fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   ('0),
    .PC_STEP    (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .flush_jump_i (flush),
    .new_pc_i     (new_pc),
    .mem          (mem_if),
    .id_pc_o      (id_pc),
    .id_inst_o    (id_inst),
    .id_valid_o   (id_valid)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return ~a ^ 32'h0BAD_F00D;
  endfunction

  // Memory accepts in the same cycle unless the scenario holds it off
  assign mem_if.inst_ack_i   = mem_if.inst_req_o & ~ack_block;
  assign mem_if.inst_rdata_i = mem_word(mem_if.inst_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every valid IF/ID word must be the next expected PC with its data
  always @(posedge clk) begin
    #2;
    if (sb_en) begin
      checks++;
      if (id_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: delivered pc=%h inst=%h, required no delivery", id_pc, id_inst);
        end else begin
          sb_pc = exp_q.pop_front();
          if (id_pc !== sb_pc || id_inst !== mem_word(sb_pc)) begin
            errors++;
            $display("FAIL sb_order: got pc=%h inst=%h, required pc=%h inst=%h",
                     id_pc, id_inst, sb_pc, mem_word(sb_pc));
          end
        end
      end else if (id_valid !== 1'b0 || id_inst !== NOP_INST) begin
        errors++;
        $display("FAIL sb_bubble: valid=%b inst=%h, required valid=0 inst=%h", id_valid, id_inst, NOP_INST);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    stall     = '0;
    new_pc    = '0;
    ack_block = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_req_addr(input logic [AW-1:0] a, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (mem_if.inst_req_o === 1'b1 && mem_if.inst_addr_o === a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_until_empty(input int budget, output bit ok);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc();
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = '0; new_pc = '0; ack_block = 1'b0; sb_en = 1'b0;
    cyc();
    cyc();
    checks++; if (mem_if.inst_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", mem_if.inst_req_o); end
    checks++; if (mem_if.inst_addr_o !== '0) begin errors++; $display("FAIL reset_addr: got %h, required 0", mem_if.inst_addr_o); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", id_valid); end
    checks++; if (id_inst !== NOP_INST) begin errors++; $display("FAIL reset_inst: got %h, required %h", id_inst, NOP_INST); end
    checks++; if (id_pc !== '0) begin errors++; $display("FAIL reset_pc: got %h, required 0", id_pc); end
    sb_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] iss[$];
    int            del_k[$];
    logic [AW-1:0] exp_addr[3];
    exp_addr = '{32'h0, 32'h4, 32'h8};
    apply_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    for (int k = 1; k <= 40 && exp_q.size() != 0; k++) begin
      cyc();
      if (mem_if.inst_req_o === 1'b1 && mem_if.inst_ack_i === 1'b1) iss.push_back(mem_if.inst_addr_o);
      if (id_valid === 1'b1) del_k.push_back(k);
    end
    ack_block = 1'b1;
    checks++; if (iss.size() !== 3) begin errors++; $display("FAIL b2b_req_count: got %0d, required 3", iss.size()); end
    for (int i = 0; i < iss.size() && i < 3; i++) begin
      checks++; if (iss[i] !== exp_addr[i]) begin errors++; $display("FAIL b2b_addr%0d: got %h, required %h", i, iss[i], exp_addr[i]); end
    end
    checks++; if (del_k.size() !== 3) begin errors++; $display("FAIL b2b_del_count: got %0d, required 3", del_k.size()); end
    if (del_k.size() > 0) begin
      checks++; if (del_k[0] !== 2) begin errors++; $display("FAIL b2b_latency: first valid at cycle %0d, required 2", del_k[0]); end
    end
    for (int i = 1; i < del_k.size(); i++) begin
      checks++; if (del_k[i] - del_k[i-1] !== 2) begin errors++; $display("FAIL b2b_spacing%0d: got %0d cycles, required 2", i, del_k[i] - del_k[i-1]); end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_pending: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_hold();
    bit ok;
    apply_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    wait_req_addr(32'h8, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hold_reach: request for 8 seen=%b, required 1", ok); end
    stall = 6'b000111;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (mem_if.inst_req_o !== 1'b0) begin errors++; $display("FAIL hold_req%0d: got %b, required 0", i, mem_if.inst_req_o); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL hold_valid%0d: got %b, required 0", i, id_valid); end
    end
    stall = '0;
    cyc();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8) begin errors++; $display("FAIL hold_release_id: got valid=%b pc=%h, required 1/8", id_valid, id_pc); end
    checks++; if (mem_if.inst_req_o !== 1'b1 || mem_if.inst_addr_o !== 32'hC) begin errors++; $display("FAIL hold_next_req: got req=%b addr=%h, required 1/c", mem_if.inst_req_o, mem_if.inst_addr_o); end
    ack_block = 1'b1;
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL hold_pending: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_stall_if();
    bit ok;
    apply_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    wait_req_addr(32'h0, 10, ok);
    cyc();
    checks++; if (ok !== 1'b1 || id_valid !== 1'b1) begin errors++; $display("FAIL sif_start: got reached=%b valid=%b, required 1/1", ok, id_valid); end
    stall = 6'b000011;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL sif_bubble%0d: got valid=%b, required 0", i, id_valid); end
    end
    stall = '0;
    run_until_empty(40, ok);
    ack_block = 1'b1;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sif_resume: %0d entries undelivered, required 0", exp_q.size()); end
  endtask

  task automatic test_flush_drain();
    bit ok;
    apply_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    exp_q.push_back(32'h100);
    wait_req_addr(32'h10, 60, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drain_reach: request for 10 seen=%b, required 1", ok); end
    ack_block = 1'b1;
    flush     = 1'b1;
    new_pc    = 32'h80;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 0) new_pc = 32'h100;
      if (i == 1) flush = 1'b0;
      checks++; if (mem_if.inst_req_o !== 1'b1 || mem_if.inst_addr_o !== 32'h10) begin errors++; $display("FAIL drain_stable%0d: got req=%b addr=%h, required 1/10", i, mem_if.inst_req_o, mem_if.inst_addr_o); end
    end
    ack_block = 1'b0;
    cyc();
    checks++; if (mem_if.inst_req_o !== 1'b1 || mem_if.inst_addr_o !== 32'h100) begin errors++; $display("FAIL drain_redirect: got req=%b addr=%h, required 1/100", mem_if.inst_req_o, mem_if.inst_addr_o); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL drain_discard: got valid=%b, required 0", id_valid); end
    run_until_empty(20, ok);
    ack_block = 1'b1;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drain_target: %0d entries undelivered, required 0", exp_q.size()); end
  endtask

  task automatic test_flush_ack();
    bit ok;
    apply_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h200);
    wait_req_addr(32'h8, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fack_reach: request for 8 seen=%b, required 1", ok); end
    flush  = 1'b1;
    new_pc = 32'h200;
    stall  = 6'b000010;
    cyc();
    flush = 1'b0;
    stall = '0;
    checks++; if (mem_if.inst_req_o !== 1'b1 || mem_if.inst_addr_o !== 32'h200) begin errors++; $display("FAIL fack_req: got req=%b addr=%h, required 1/200", mem_if.inst_req_o, mem_if.inst_addr_o); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fack_bubble: got valid=%b, required 0", id_valid); end
    run_until_empty(20, ok);
    ack_block = 1'b1;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fack_target: %0d entries undelivered, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_and_wrap();
    bit ok;
    apply_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    wait_req_addr(32'h8, 40, ok);
    ack_block = 1'b1;
    cyc();
    checks++; if (ok !== 1'b1 || mem_if.inst_req_o !== 1'b1) begin errors++; $display("FAIL rmid_reach: got reached=%b req=%b, required 1/1", ok, mem_if.inst_req_o); end
    rst = 1'b1;
    cyc();
    checks++; if (mem_if.inst_req_o !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b, required 0", mem_if.inst_req_o); end
    checks++; if (mem_if.inst_addr_o !== '0) begin errors++; $display("FAIL rmid_addr: got %h, required 0", mem_if.inst_addr_o); end
    checks++; if (id_valid !== 1'b0 || id_inst !== NOP_INST) begin errors++; $display("FAIL rmid_id: got valid=%b inst=%h, required 0/%h", id_valid, id_inst, NOP_INST); end
    checks++; if (id_pc !== '0) begin errors++; $display("FAIL rmid_pc: got %h, required 0", id_pc); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rmid_pending: got %0d left, required 0", exp_q.size()); end
    rst       = 1'b0;
    flush     = 1'b1;
    new_pc    = 32'hFFFF_FFFC;
    ack_block = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    cyc();
    flush = 1'b0;
    checks++; if (mem_if.inst_req_o !== 1'b1 || mem_if.inst_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got req=%b addr=%h, required 1/fffffffc", mem_if.inst_req_o, mem_if.inst_addr_o); end
    wait_req_addr(32'h0, 10, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_next: request for 0 after fffffffc seen=%b, required 1", ok); end
    run_until_empty(10, ok);
    ack_block = 1'b1;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_deliver: %0d entries undelivered, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold();
    test_stall_if();
    test_flush_drain();
    test_flush_ack();
    test_reset_mid_and_wrap();
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
